// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings, IR field
// positions, reset PC default and the opcode constants the controller decodes.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int FUNC_MSB   = 5;
    localparam int FUNC_LSB   = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Instruction addresses are word aligned; the two low bits never survive.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory req/ack bus. The fetch unit is the master; memory is the slave.
interface instr_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register with the next-PC mux (sequential step or aligned
// branch target). Runs independently of the fetch FSM.
module fetch_pc_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_we,
    input  logic        pcsrc,
    input  logic [31:0] branch_target,
    output logic [31:0] pc
);

    logic [31:0] pc_d;
    logic [31:0] pc_q;

    // The increment wraps modulo 2^32 and is realigned so an odd PC_STEP can
    // never leave the PC off a word boundary.
    always_comb begin
        pc_d = pc_q;
        if (pc_we) begin
            if (pcsrc) begin
                pc_d = align_word(branch_target);
            end else begin
                pc_d = align_word(pc_q + PC_STEP);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, runs the imem req/ack handshake and
// decodes IR fields. Optional fetch timeout enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter int          TIMEOUT  = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_start,
    input  logic                       pc_we,
    input  logic                       pcsrc,
    input  logic [31:0]                branch_target,
    instr_fetch_unit_if.master         bus,
    output logic [31:0]                pc,
    output logic [31:0]                ir,
    output logic [5:0]                 opcode,
    output logic [4:0]                 rs,
    output logic [4:0]                 rt,
    output logic [4:0]                 rd,
    output logic [5:0]                 func,
    output logic [15:0]                imm,
    output logic                       ir_valid,
    output logic                       busy,
    output logic                       fetch_err
);

    fetch_state_e state_q, state_d;
    logic         imem_req_q, imem_req_d;
    logic [31:0]  imem_addr_q, imem_addr_d;
    logic [31:0]  ir_q, ir_d;
    logic         ir_valid_q, ir_valid_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT >= 256) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fetch_err_q, fetch_err_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT == 0);
`endif

    fetch_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk           (clk),
        .reset         (reset),
        .pc_we         (pc_we),
        .pcsrc         (pcsrc),
        .branch_target (branch_target),
        .pc            (pc)
    );

    always_comb begin
        state_d     = state_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        ir_d        = ir_q;
        ir_valid_d  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        cnt_d       = cnt_q;
        fetch_err_d = fetch_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // The address is the PC before any same-cycle pc_we lands.
                if (fetch_start) begin
                    state_d     = ST_REQ;
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d       = '0;
                    fetch_err_d = 1'b0;
`endif
                end
            end
            ST_REQ: begin
                // An ack on the timeout cycle still loads the word normally.
                if (bus.imem_ack) begin
                    state_d    = ST_DONE;
                    imem_req_d = 1'b0;
                    ir_d       = bus.imem_rdata;
                    ir_valid_d = 1'b1;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_IDLE;
                    imem_req_d  = 1'b0;
                    fetch_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                imem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q       <= '0;
            fetch_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q       <= cnt_d;
            fetch_err_q <= fetch_err_d;
`endif
        end
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = imem_addr_q;
    assign ir            = ir_q;
    assign ir_valid      = ir_valid_q;
    assign busy          = (state_q != ST_IDLE);
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err     = fetch_err_q;
`else
    assign fetch_err     = 1'b0;
`endif

    assign opcode = ir_q[OPCODE_MSB:OPCODE_LSB];
    assign rs     = ir_q[RS_MSB:RS_LSB];
    assign rt     = ir_q[RT_MSB:RT_LSB];
    assign rd     = ir_q[RD_MSB:RD_LSB];
    assign func   = ir_q[FUNC_MSB:FUNC_LSB];
    assign imm    = ir_q[IMM_MSB:IMM_LSB];

endmodule
